// File: rtl/snake_body_unit.sv
// Snake body and movement engine: segment storage, timed stepping, collision/apple detection
// and per-cell occupancy queries. Define SNAKE_WRAP_EN to make grid edges wrap instead of killing.
module snake_body_unit #(
   parameter int GRID_W      = 40,
   parameter int GRID_H      = 30,
   parameter int MAX_LEN     = 16,
   parameter int STEP_CYCLES = 12_500_000
) (
   input  logic       CLK_50M,
   input  logic       RSTn,
   input  logic       key1_press,
   input  logic       key2_press,
   input  logic       key3_press,
   input  logic       key4_press,
   input  logic [1:0] game_status,
   input  logic       restart,
   input  logic [5:0] apple_x,
   input  logic [4:0] apple_y,
   input  logic [5:0] query_x,
   input  logic [4:0] query_y,
   output logic       head_hit,
   output logic       body_hit,
   output logic [5:0] head_x,
   output logic [4:0] head_y,
   output logic [4:0] snake_len,
   output logic       apple_eaten,
   output logic       hit_wall,
   output logic       hit_body
);

   localparam int               CNT_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
   localparam logic [5:0]       X_MAX     = 6'(GRID_W - 1);
   localparam logic [4:0]       Y_MAX     = 5'(GRID_H - 1);
   localparam logic [4:0]       LEN_MAX   = 5'(MAX_LEN);
   localparam logic [4:0]       LEN_INIT  = 5'd3;
   localparam logic [1:0]       STAT_PLAY = 2'b10;
   localparam logic [1:0]       DIR_UP    = 2'd0;
   localparam logic [1:0]       DIR_DOWN  = 2'd1;
   localparam logic [1:0]       DIR_LEFT  = 2'd2;
   localparam logic [1:0]       DIR_RIGHT = 2'd3;
`ifdef SNAKE_WRAP_EN
   localparam logic             WRAP_EN   = 1'b1;
`else
   localparam logic             WRAP_EN   = 1'b0;
`endif

   logic [5:0]       r_seg_x [MAX_LEN];
   logic [4:0]       r_seg_y [MAX_LEN];
   logic [4:0]       r_len;
   logic [1:0]       r_cur_dir, r_next_dir;
   logic [CNT_W-1:0] r_cnt;
   logic             r_hit_wall, r_hit_body, r_apple_eaten, r_head_hit, r_body_hit;

   logic             w_run, w_step, w_move, w_eat, w_off_grid, w_self_hit;
   logic [5:0]       w_cand_x;
   logic [4:0]       w_cand_y;
   logic [1:0]       w_key_dir, w_ref_dir;
   logic             w_key_valid, w_key_ok, w_q_head, w_q_body;

   assign w_run  = (game_status == STAT_PLAY) && !r_hit_wall && !r_hit_body;
   assign w_step = w_run && (r_cnt == CNT_LAST);

   // Key priority select; at a step the reversal check uses the direction about to become current.
   always_comb begin
      w_key_valid = 1'b1;
      w_key_dir   = DIR_RIGHT;
      if (key1_press)      w_key_dir = DIR_UP;
      else if (key2_press) w_key_dir = DIR_DOWN;
      else if (key3_press) w_key_dir = DIR_LEFT;
      else if (key4_press) w_key_dir = DIR_RIGHT;
      else                 w_key_valid = 1'b0;
      w_ref_dir = w_step ? r_next_dir : r_cur_dir;
      w_key_ok  = w_key_valid && (w_key_dir != (w_ref_dir ^ 2'd1));
   end

   // Candidate head one cell along next_dir, with edge detection or wrap.
   always_comb begin
      w_cand_x   = r_seg_x[0];
      w_cand_y   = r_seg_y[0];
      w_off_grid = 1'b0;
      case (r_next_dir)
         DIR_UP: begin
            if (r_seg_y[0] == 5'd0) begin w_cand_y = Y_MAX; w_off_grid = !WRAP_EN; end
            else                    w_cand_y = r_seg_y[0] - 5'd1;
         end
         DIR_DOWN: begin
            if (r_seg_y[0] == Y_MAX) begin w_cand_y = 5'd0; w_off_grid = !WRAP_EN; end
            else                     w_cand_y = r_seg_y[0] + 5'd1;
         end
         DIR_LEFT: begin
            if (r_seg_x[0] == 6'd0) begin w_cand_x = X_MAX; w_off_grid = !WRAP_EN; end
            else                    w_cand_x = r_seg_x[0] - 6'd1;
         end
         DIR_RIGHT: begin
            if (r_seg_x[0] == X_MAX) begin w_cand_x = 6'd0; w_off_grid = !WRAP_EN; end
            else                     w_cand_x = r_seg_x[0] + 6'd1;
         end
         default: w_off_grid = 1'b0;
      endcase
   end

   // Self-collision and query matching against live segments only.
   always_comb begin
      w_self_hit = 1'b0;
      w_q_body   = 1'b0;
      w_q_head   = (r_seg_x[0] == query_x) && (r_seg_y[0] == query_y);
      for (int i = 1; i < MAX_LEN; i++) begin
         w_self_hit = w_self_hit | ((5'(i) < r_len) && (r_seg_x[i] == w_cand_x) && (r_seg_y[i] == w_cand_y));
         w_q_body   = w_q_body   | ((5'(i) < r_len) && (r_seg_x[i] == query_x)  && (r_seg_y[i] == query_y));
      end
   end

   assign w_move = w_step && !restart && !w_off_grid && !w_self_hit;
   assign w_eat  = w_move && (w_cand_x == apple_x) && (w_cand_y == apple_y);

   // Segment storage: initial layout on reset/restart, shift toward the tail on a move.
   always_ff @(posedge CLK_50M or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < MAX_LEN; i++) begin r_seg_x[i] <= 6'd0; r_seg_y[i] <= 5'd0; end
         r_seg_x[0] <= 6'd20; r_seg_x[1] <= 6'd19; r_seg_x[2] <= 6'd18;
         r_seg_y[0] <= 5'd15; r_seg_y[1] <= 5'd15; r_seg_y[2] <= 5'd15;
      end else if (restart) begin
         for (int i = 0; i < MAX_LEN; i++) begin r_seg_x[i] <= 6'd0; r_seg_y[i] <= 5'd0; end
         r_seg_x[0] <= 6'd20; r_seg_x[1] <= 6'd19; r_seg_x[2] <= 6'd18;
         r_seg_y[0] <= 5'd15; r_seg_y[1] <= 5'd15; r_seg_y[2] <= 5'd15;
      end else if (w_move) begin
         for (int i = 1; i < MAX_LEN; i++) begin r_seg_x[i] <= r_seg_x[i-1]; r_seg_y[i] <= r_seg_y[i-1]; end
         r_seg_x[0] <= w_cand_x;
         r_seg_y[0] <= w_cand_y;
      end
   end

   // Step timer, direction latch, length and sticky collision flags.
   always_ff @(posedge CLK_50M or negedge RSTn) begin
      if (!RSTn) begin
         r_cnt <= '0; r_cur_dir <= DIR_RIGHT; r_next_dir <= DIR_RIGHT; r_len <= LEN_INIT;
         r_hit_wall <= 1'b0; r_hit_body <= 1'b0; r_apple_eaten <= 1'b0;
      end else if (restart) begin
         r_cnt <= '0; r_cur_dir <= DIR_RIGHT; r_next_dir <= DIR_RIGHT; r_len <= LEN_INIT;
         r_hit_wall <= 1'b0; r_hit_body <= 1'b0; r_apple_eaten <= 1'b0;
      end else begin
         r_cnt <= (w_run && !w_step) ? r_cnt + 1'b1 : '0;
         if (w_step) r_cur_dir <= r_next_dir;
         if (w_key_ok) r_next_dir <= w_key_dir;
         if (w_step && w_off_grid) r_hit_wall <= 1'b1;
         if (w_step && !w_off_grid && w_self_hit) r_hit_body <= 1'b1;
         r_apple_eaten <= w_eat;
         if (w_eat && (r_len < LEN_MAX)) r_len <= r_len + 5'd1;
      end
   end

   // Registered occupancy answer for the display path.
   always_ff @(posedge CLK_50M or negedge RSTn) begin
      if (!RSTn) begin
         r_head_hit <= 1'b0; r_body_hit <= 1'b0;
      end else if (restart) begin
         r_head_hit <= 1'b0; r_body_hit <= 1'b0;
      end else begin
         r_head_hit <= w_q_head; r_body_hit <= w_q_body;
      end
   end

   assign head_hit    = r_head_hit;
   assign body_hit    = r_body_hit;
   assign head_x      = r_seg_x[0];
   assign head_y      = r_seg_y[0];
   assign snake_len   = r_len;
   assign apple_eaten = r_apple_eaten;
   assign hit_wall    = r_hit_wall;
   assign hit_body    = r_hit_body;

endmodule

// File: tb/tb_snake_body_unit.sv
// Self-checking bench for snake_body_unit with a short step interval (4 cycles).
module tb_snake_body_unit;

   localparam logic [1:0] ST_RESTART = 2'b00;
   localparam logic [1:0] ST_START   = 2'b01;
   localparam logic [1:0] ST_PLAY    = 2'b10;
   localparam logic [1:0] ST_DIE     = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       k1, k2, k3, k4;
   logic [1:0] game_status;
   logic       restart;
   logic [5:0] apple_x, query_x;
   logic [4:0] apple_y, query_y;
   logic       head_hit, body_hit, apple_eaten, hit_wall, hit_body;
   logic [5:0] head_x;
   logic [4:0] head_y, snake_len;

   int checks = 0;
   int errors = 0;

   typedef struct { logic [5:0] qx; logic [4:0] qy; logic eh; logic eb; } qvec_t;
   qvec_t vecs [7];
   qvec_t sb_q [$];

   snake_body_unit #(.STEP_CYCLES(4)) dut (
      .CLK_50M(clk), .RSTn(rst_n),
      .key1_press(k1), .key2_press(k2), .key3_press(k3), .key4_press(k4),
      .game_status(game_status), .restart(restart),
      .apple_x(apple_x), .apple_y(apple_y), .query_x(query_x), .query_y(query_y),
      .head_hit(head_hit), .body_hit(body_hit), .head_x(head_x), .head_y(head_y),
      .snake_len(snake_len), .apple_eaten(apple_eaten), .hit_wall(hit_wall), .hit_body(hit_body)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic query(input logic [5:0] qx, input logic [4:0] qy, input logic eh, input logic eb);
      qvec_t e;
      query_x = qx; query_y = qy;
      sb_q.push_back('{qx, qy, eh, eb});
      @(negedge clk);
      if (sb_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL query_scoreboard: got empty queue expected an entry");
      end else begin
         e = sb_q.pop_front();
         chk($sformatf("head_hit(%0d,%0d)", e.qx, e.qy), {31'd0, head_hit}, {31'd0, e.eh});
         chk($sformatf("body_hit(%0d,%0d)", e.qx, e.qy), {31'd0, body_hit}, {31'd0, e.eb});
      end
   endtask

   task automatic pulse(input int k);
      k1 = (k == 1); k2 = (k == 2); k3 = (k == 3); k4 = (k == 4);
      @(negedge clk);
      k1 = 1'b0; k2 = 1'b0; k3 = 1'b0; k4 = 1'b0;
   endtask

   task automatic run_steps(input int n);
      game_status = ST_PLAY;
      repeat (4 * n) @(negedge clk);
      game_status = ST_START;
   endtask

   task automatic do_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   initial begin
      vecs[0] = '{6'd20, 5'd15, 1'b1, 1'b0};
      vecs[1] = '{6'd19, 5'd15, 1'b0, 1'b1};
      vecs[2] = '{6'd18, 5'd15, 1'b0, 1'b1};
      vecs[3] = '{6'd17, 5'd15, 1'b0, 1'b0};
      vecs[4] = '{6'd30, 5'd3,  1'b0, 1'b0};
      vecs[5] = '{6'd21, 5'd15, 1'b0, 1'b0};
      vecs[6] = '{6'd20, 5'd14, 1'b0, 1'b0};

      rst_n = 1'b0; k1 = 1'b0; k2 = 1'b0; k3 = 1'b0; k4 = 1'b0;
      game_status = ST_RESTART; restart = 1'b0;
      apple_x = 6'd0; apple_y = 5'd0; query_x = 6'd20; query_y = 5'd15;
      repeat (2) @(negedge clk);
      chk("rst_head_x", 32'(head_x), 32'd20);
      chk("rst_head_y", 32'(head_y), 32'd15);
      chk("rst_len", 32'(snake_len), 32'd3);
      chk("rst_flags", {29'd0, hit_wall, hit_body, apple_eaten}, 32'd0);
      chk("rst_query", {30'd0, head_hit, body_hit}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) query(vecs[i].qx, vecs[i].qy, vecs[i].eh, vecs[i].eb);

      // First step lands exactly 4 cycles into PLAY
      game_status = ST_PLAY;
      repeat (3) @(negedge clk);
      chk("pre_step_head_x", 32'(head_x), 32'd20);
      @(negedge clk);
      chk("step1_head_x", 32'(head_x), 32'd21);
      chk("step1_head_y", 32'(head_y), 32'd15);
      game_status = ST_START;
      query(6'd19, 5'd15, 1'b0, 1'b1);
      query(6'd18, 5'd15, 1'b0, 1'b0);
      query(6'd21, 5'd15, 1'b1, 1'b0);
      run_steps(3);
      chk("step4_head_x", 32'(head_x), 32'd24);

      // Leaving PLAY discards the partial count
      game_status = ST_PLAY;
      repeat (2) @(negedge clk);
      game_status = ST_START;
      @(negedge clk);
      game_status = ST_PLAY;
      repeat (3) @(negedge clk);
      chk("discard_head_x", 32'(head_x), 32'd24);
      @(negedge clk);
      chk("after_discard_head_x", 32'(head_x), 32'd25);
      game_status = ST_START;

      // Reversal rejected; UP then LEFT within one interval only turns UP
      pulse(3);
      run_steps(1);
      chk("rev_head_x", 32'(head_x), 32'd26);
      chk("rev_head_y", 32'(head_y), 32'd15);
      pulse(1);
      pulse(3);
      run_steps(1);
      chk("up_head_x", 32'(head_x), 32'd26);
      chk("up_head_y", 32'(head_y), 32'd14);

      do_restart();
      chk("restart_head_x", 32'(head_x), 32'd20);
      chk("restart_head_y", 32'(head_y), 32'd15);
      query(6'd20, 5'd15, 1'b1, 1'b0);

      // Restart coinciding with a step event wins
      game_status = ST_PLAY;
      repeat (3) @(negedge clk);
      do_restart();
      game_status = ST_START;
      chk("restart_vs_step_head_x", 32'(head_x), 32'd20);

      // Apple: one-cycle pulse, growth, tail retained
      apple_x = 6'd21; apple_y = 5'd15;
      game_status = ST_PLAY;
      repeat (4) @(negedge clk);
      chk("apple_pulse", {31'd0, apple_eaten}, 32'd1);
      chk("apple_len", 32'(snake_len), 32'd4);
      game_status = ST_START;
      @(negedge clk);
      chk("apple_pulse_end", {31'd0, apple_eaten}, 32'd0);
      query(6'd18, 5'd15, 1'b0, 1'b1);
      for (int k = 0; k < 13; k++) begin
         apple_x = 6'(22 + k);
         run_steps(1);
         chk($sformatf("grow_len_%0d", k), 32'(snake_len), (5 + k > 16) ? 32'd16 : 32'(5 + k));
         chk($sformatf("grow_head_%0d", k), 32'(head_x), 32'(22 + k));
      end
      apple_x = 6'd0; apple_y = 5'd0;
      query(6'd19, 5'd15, 1'b0, 1'b1);
      query(6'd18, 5'd15, 1'b0, 1'b0);

      // Wall at the right edge
      run_steps(5);
      chk("edge_head_x", 32'(head_x), 32'd39);
      game_status = ST_PLAY;
      repeat (4) @(negedge clk);
`ifdef SNAKE_WRAP_EN
      chk("wrap_head_x", 32'(head_x), 32'd0);
      chk("wrap_hit_wall", {31'd0, hit_wall}, 32'd0);
`else
      chk("wall_flag", {31'd0, hit_wall}, 32'd1);
      chk("wall_head_x", 32'(head_x), 32'd39);
      repeat (8) @(negedge clk);
      chk("wall_frozen_head_x", 32'(head_x), 32'd39);
      chk("wall_sticky", {31'd0, hit_wall}, 32'd1);
`endif
      game_status = ST_DIE;
      repeat (2) @(negedge clk);
      do_restart();
      game_status = ST_START;
      chk("wall_clear", {31'd0, hit_wall}, 32'd0);
      chk("wall_restart_len", 32'(snake_len), 32'd3);
      chk("wall_restart_head_x", 32'(head_x), 32'd20);

      // Length-5 snake turned UP, LEFT, DOWN into itself
      apple_x = 6'd21; apple_y = 5'd15;
      run_steps(1);
      apple_x = 6'd22;
      run_steps(1);
      apple_x = 6'd0; apple_y = 5'd0;
      chk("body_len", 32'(snake_len), 32'd5);
      pulse(1);
      run_steps(1);
      chk("body_up_y", 32'(head_y), 32'd14);
      pulse(3);
      run_steps(1);
      chk("body_left_x", 32'(head_x), 32'd21);
      pulse(2);
      run_steps(1);
      chk("body_hit", {31'd0, hit_body}, 32'd1);
      chk("body_hit_head", {26'd0, head_x}, 32'd21);
      chk("body_hit_head_y", 32'(head_y), 32'd14);
      chk("body_no_wall", {31'd0, hit_wall}, 32'd0);
      game_status = ST_DIE;
      repeat (6) @(negedge clk);
      chk("body_sticky", {31'd0, hit_body}, 32'd1);
      query(6'd21, 5'd14, 1'b1, 1'b0);
      query(6'd21, 5'd15, 1'b0, 1'b1);
      do_restart();
      chk("body_clear", {31'd0, hit_body}, 32'd0);
      chk("body_restart_query", {30'd0, head_hit, body_hit}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/snake_body_unit.md
# snake_body_unit

Snake body and movement engine for the snake game. It sits directly downstream of the game control unit: it consumes `game_status`, `restart` and the four debounced key pulses, and feeds `hit_wall` and `hit_body` back to that unit. It holds the snake segment coordinates, advances the snake once per step interval while the game is in PLAY, detects collisions and apple consumption, and answers per-cell occupancy queries from the display path.

## Interface
- `GRID_W`, 40: grid width in cells; x range is 0..GRID_W-1.
- `GRID_H`, 30: grid height in cells; y range is 0..GRID_H-1.
- `MAX_LEN`, 16: segment storage depth and the maximum snake length.
- `STEP_CYCLES`, 12_500_000: clock cycles per move (4 moves/s at 50 MHz).

- `CLK_50M` in 1: system clock. One clock domain.
- `RSTn` in 1: reset, asynchronous, active-low.
- `key1_press`..`key4_press` in 1 each: single-cycle key pulses. key1 = UP, key2 = DOWN, key3 = LEFT, key4 = RIGHT.
- `game_status` in 2: 00 RESTART, 01 START, 10 PLAY, 11 DIE.
- `restart` in 1: high means reinitialise the snake.
- `apple_x` in 6, `apple_y` in 5: current apple cell.
- `query_x` in 6, `query_y` in 5: cell being queried by the display.
- `head_hit` out 1: queried cell is the head. Registered.
- `body_hit` out 1: queried cell is a non-head live segment. Registered.
- `head_x` out 6, `head_y` out 5: current head cell.
- `snake_len` out 5: number of live segments, 3..MAX_LEN.
- `apple_eaten` out 1: one-cycle pulse when the head moves onto the apple.
- `hit_wall` out 1: sticky wall collision flag.
- `hit_body` out 1: sticky self collision flag.

## Operation
- **Initial state** (applied on reset or while `restart`=1):
  - seg0 = (20,15), seg1 = (19,15), seg2 = (18,15).
  - `snake_len` = 3; `cur_dir` = `next_dir` = RIGHT.
  - Step counter = 0; all flags = 0; `head_hit` = `body_hit` = 0.
  - Unused segments are cleared to (0,0).
- **Direction latch:**
  - Active in every status.
  - When key pulses coincide, the priority is key1 > key2 > key3 > key4.
  - A press is ignored if it is the opposite of `cur_dir`. The check is against `cur_dir`, not `next_dir`, so two quick presses cannot produce a reversal.
  - Otherwise the press loads `next_dir`.
- **Step counter:**
  - Runs only while `game_status`=PLAY and both hit flags are 0.
  - Otherwise it is held at 0.
  - It wraps at STEP_CYCLES-1, and that terminal cycle is the step event.
- **Step event:**
  - `cur_dir` <= `next_dir`.
  - Candidate head = seg0 moved one cell in `next_dir`.
  - If the candidate leaves the grid: set `hit_wall`; the body does not move.
  - Else, if the candidate equals any seg1..seg[len-1]: set `hit_body`; the body does not move. The tail counts as a collision.
  - Else: seg[i] <= seg[i-1] for i = 1..MAX_LEN-1, and seg0 <= candidate.
  - If the candidate equals (`apple_x`,`apple_y`): pulse `apple_eaten` and set `snake_len` <= min(len+1, MAX_LEN). The old tail is kept through the shift.
- **Arithmetic:** coordinates are unsigned. Comparisons are equality only. Segments with index >= `snake_len` never match.
- **Hit flags:** `hit_wall` and `hit_body` stay set until `restart` or reset. The game control unit observes them in PLAY and moves to DIE.
- **Query:** in every cycle, `head_hit` and `body_hit` are computed from the query inputs and registered.

## Timing
- All outputs are 0 at reset, except:
  - `head_x`/`head_y` = 20/15.
  - `snake_len` = 3.
- Key pulse at edge N: `next_dir` updates at N+1.
- A key pulse that coincides with a step event applies to the following step.
- Step event in the cycle where counter = STEP_CYCLES-1. Updated `head_x`/`head_y`, `snake_len`, hit flag and `apple_eaten` all appear after the next edge. `apple_eaten` is high for exactly 1 cycle.
- First step happens STEP_CYCLES cycles after `game_status` becomes PLAY.
- Query latency: 1 cycle.
- `restart` overrides everything in the same cycle, including a simultaneous step event.
- Leaving PLAY mid-interval discards the partial count.
- Asynchronous reset mid-step aborts the step cleanly, with no partial shift.

## Configuration
- `SNAKE_WRAP_EN` defined:
  - Grid edges wrap: x GRID_W-1 → 0 and 0 → GRID_W-1; y likewise with GRID_H.
  - `hit_wall` is tied to 0.
- `SNAKE_WRAP_EN` undefined: leaving the grid sets `hit_wall`, as described above.

## Test plan
All scenarios use STEP_CYCLES=4.
- **Reset then PLAY, no keys:** after 4 cycles head = (21,15), seg2 = (19,15); after 3 more steps head = (24,15).
- **Reversal:** in PLAY facing RIGHT, pulse key3 → no change; head keeps moving +x. Pulse key1 then key3 within one interval → turns UP only.
- **Apple:** apple at (21,15), step → `apple_eaten` 1 cycle high, `snake_len` 3 → 4, tail stays at (18,15). Repeat to MAX_LEN → `snake_len` saturates at 16.
- **Wall:** head at (39,y) moving RIGHT, step → `hit_wall` = 1, head unchanged, counter frozen. Then `restart` = 1 → initial state restored. With `SNAKE_WRAP_EN` defined → head = (0,y), `hit_wall` stays 0.
- **Body:** length-5 snake steered UP, LEFT, DOWN into itself → `hit_body` = 1 on that step, and it stays set through DIE until `restart`.
- **Query:**
  - query (20,15) at reset → `head_hit` = 1 next cycle.
  - query (18,15) → `body_hit` = 1.
  - query (30,3) → both 0.
